ifetch_buffer: RTL

Instruction prefetch buffer between the instruction memory and the fetch stage of riscv_core. Drives the imem address and captures the combinational read data into a small FIFO tagged with its PC. Presents the FIFO head to the core with a valid/ready handshake. On a branch/jump redirect it flushes the FIFO and restarts fetching at the new target.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fifo_sync.sv | 72 +++++++
 rtl/ifetch_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch path.
//   XLEN          : default address / instruction width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0)
//   pc_t          : program-counter type
//   fetch_entry_t : one buffered fetch {instr, pc}
//   fetch_state_t : prefetch FSM states
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [XLEN-1:0] pc_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush, used as the prefetch queue.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, pop   : enqueue din / dequeue head (same cycle allowed, also when full)
//   flush       : empties the FIFO; wins over push and pop
//   din, dout   : write data / registered head entry (no bypass from din)
//   count       : current occupancy, 0..DEPTH
module fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A pop on empty is ignored; a push on full only lands when a pop frees the slot.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only: not reset, contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= FULL_CNT);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && (r_count == '0)));

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer between imem and the fetch stage.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   imem_addr         : fetch address (imem answers combinationally)
//   imem_rdata        : instruction word at imem_addr
//   instr_valid/ready : head handshake toward the core
//   instr, instr_pc   : head instruction and its PC (NOP / 0 when empty)
//   redirect(_pc)     : flush and refetch from redirect_pc (low bits dropped)
//   misalign          : one-cycle registered flag for a redirect with pc[1:0] != 0
//   count             : FIFO occupancy
module ifetch_buffer #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       misalign,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH-1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_misalign;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [2*XLEN-1:0] w_din;
  logic [2*XLEN-1:0] w_dout;

  // Redirect squashes both the push of the current fetch and any pop offered.
  assign w_pop  = instr_valid && instr_ready && !redirect;
  assign w_push = (r_state != S_BOOT) && !redirect &&
                  ((w_count != FULL_CNT) || w_pop);
  assign w_din  = {imem_rdata, r_fetch_pc};

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_BOOT:  w_state_nxt = S_FETCH;
        S_FETCH: if (w_push && !w_pop && (w_count == LAST_CNT)) w_state_nxt = S_FULL;
        S_FULL:  if (w_pop) w_state_nxt = S_FETCH;
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect)    r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_push) r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign misalign    = r_misalign;
  assign count       = w_count;
  assign instr_valid = (w_count != '0);
  assign instr       = instr_valid ? w_dout[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign instr_pc    = instr_valid ? w_dout[XLEN-1:0]      : '0;

endmodule
